// File: rtl/dt_classifier_engine_if.sv
// Handshake bundle for dt_classifier_engine: node-table config port,
// feature-vector input port, and the held classification result port.
interface dt_classifier_engine_if #(
  parameter int NUM_FEAT = 6,
  parameter int FEAT_W   = 32,
  parameter int NODE_AW  = 8,
  parameter int CLASS_W  = 4
);
  localparam int FIDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int NODE_W = 1 + FIDX_W + FEAT_W + 2 * NODE_AW + CLASS_W;

  logic                       cfg_we;
  logic [NODE_AW-1:0]         cfg_addr;
  logic [NODE_W-1:0]          cfg_wdata;
  logic                       cfg_ready;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_FEAT*FEAT_W-1:0] in_feat;
  logic                       out_valid;
  logic                       out_ready;
  logic [CLASS_W-1:0]         out_class;
  logic                       out_attack;
  logic [NODE_AW-1:0]         out_node;
  logic [7:0]                 out_depth;
  logic                       out_error;
  logic                       busy;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    input  cfg_ready, in_ready, out_valid, out_class, out_attack,
           out_node, out_depth, out_error, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    output cfg_ready, in_ready, out_valid, out_class, out_attack,
           out_node, out_depth, out_error, busy
  );
endinterface

// File: rtl/dt_classifier_engine.sv
// Table-driven decision-tree classifier for CAN frame features.
// Walks a programmable node table one node per two cycles (FETCH, EVAL)
// and presents a held verdict: class, final node, depth and error flag.
module dt_classifier_engine #(
  parameter int NUM_FEAT  = 6,
  parameter int FEAT_W    = 32,
  parameter int NODE_AW   = 8,
  parameter int CLASS_W   = 4,
  parameter int MAX_DEPTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  dt_classifier_engine_if.slave bus
);
  localparam int FIDX_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int NODE_W   = 1 + FIDX_W + FEAT_W + 2 * NODE_AW + CLASS_W;
  localparam int R_LSB    = CLASS_W;
  localparam int L_LSB    = CLASS_W + NODE_AW;
  localparam int THR_LSB  = CLASS_W + 2 * NODE_AW;
  localparam int FIDX_LSB = THR_LSB + FEAT_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_RESULT} state_e;

  state_e                     state_q, state_d;
  logic [NODE_W-1:0]          mem_q [2**NODE_AW];
  logic [NODE_W-1:0]          node_q;
  logic [NODE_AW-1:0]         addr_q, addr_d;
  logic [7:0]                 depth_q, depth_d;
  logic [NUM_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [CLASS_W-1:0]         out_class_q, out_class_d;
  logic [NODE_AW-1:0]         out_node_q, out_node_d;
  logic [7:0]                 out_depth_q, out_depth_d;
  logic                       out_error_q, out_error_d;

  // Decoded fields of the node currently under evaluation.
  logic                node_leaf;
  logic [FIDX_W-1:0]   node_fidx;
  logic [FEAT_W-1:0]   node_thr;
  logic [NODE_AW-1:0]  node_left;
  logic [NODE_AW-1:0]  node_right;
  logic [CLASS_W-1:0]  node_class;
  logic [FEAT_W-1:0]   feat_sel;
  logic                fidx_bad;
  logic                depth_hit;

  assign node_leaf  = node_q[NODE_W-1];
  assign node_fidx  = node_q[FIDX_LSB +: FIDX_W];
  assign node_thr   = node_q[THR_LSB +: FEAT_W];
  assign node_left  = node_q[L_LSB +: NODE_AW];
  assign node_right = node_q[R_LSB +: NODE_AW];
  assign node_class = node_q[CLASS_W-1:0];
  assign fidx_bad   = (32'(node_fidx) >= 32'(NUM_FEAT));
  assign depth_hit  = (depth_q == 8'(MAX_DEPTH));

  // Mux the feature addressed by the node; out-of-range indices are caught by fidx_bad.
  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      feat_sel = (node_fidx == FIDX_W'(i)) ? feat_q[i*FEAT_W +: FEAT_W] : feat_sel;
    end
  end

  // Node table: writes only while idle (so a same-cycle handshake sees them), synchronous read in FETCH.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state_q == S_IDLE)) begin
      mem_q[bus.cfg_addr] <= bus.cfg_wdata;
    end
    if (state_q == S_FETCH) begin
      node_q <= mem_q[addr_q];
    end
  end

  // Next-state and datapath: accept, fetch, evaluate rules in priority order, hold the result.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    depth_d     = depth_q;
    feat_d      = feat_q;
    out_class_d = out_class_q;
    out_node_d  = out_node_q;
    out_depth_d = out_depth_q;
    out_error_d = out_error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          feat_d  = bus.in_feat;
          addr_d  = '0;
          depth_d = 8'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        out_node_d  = addr_q;
        out_depth_d = depth_q;
        if (node_leaf) begin
          out_class_d = node_class;
          out_error_d = 1'b0;
          state_d     = S_RESULT;
        end else if (fidx_bad || depth_hit) begin
          out_class_d = '0;
          out_error_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          addr_d  = (feat_sel <= node_thr) ? node_left : node_right;
          depth_d = depth_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_RESULT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any traversal or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      depth_q     <= 8'd0;
      feat_q      <= '0;
      out_class_q <= '0;
      out_node_q  <= '0;
      out_depth_q <= 8'd0;
      out_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      depth_q     <= depth_d;
      feat_q      <= feat_d;
      out_class_q <= out_class_d;
      out_node_q  <= out_node_d;
      out_depth_q <= out_depth_d;
      out_error_q <= out_error_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.cfg_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = (state_q == S_RESULT);
  assign bus.out_class  = out_class_q;
  assign bus.out_attack = |out_class_q;
  assign bus.out_node   = out_node_q;
  assign bus.out_depth  = out_depth_q;
  assign bus.out_error  = out_error_q;
endmodule

// File: tb/tb_dt_classifier_engine.sv
// Self-checking bench for dt_classifier_engine: directed scenarios plus a
// randomized tree, each verdict compared against a behavioural tree walk.
module tb_dt_classifier_engine;
  localparam int NUM_FEAT  = 6;
  localparam int FEAT_W    = 32;
  localparam int NODE_AW   = 8;
  localparam int CLASS_W   = 4;
  localparam int MAX_DEPTH = 32;
  localparam int NODE_W    = 1 + 3 + FEAT_W + 2 * NODE_AW + CLASS_W;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // Reference table, updated only for writes the engine must accept.
  int       m_leaf [256];
  int       m_fidx [256];
  bit [31:0] m_thr [256];
  int       m_l    [256];
  int       m_r    [256];
  int       m_cls  [256];
  bit [31:0] feat_v [NUM_FEAT];

  dt_classifier_engine_if #(.NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W),
                            .NODE_AW(NODE_AW), .CLASS_W(CLASS_W)) bus_if ();

  dt_classifier_engine #(.NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW),
                         .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural tree walk: returns the verdict the engine must produce.
  function automatic void model(output int cls, output int node, output int depth, output int err);
    int a;
    int d;
    bit done;
    a = 0; d = 0; done = 1'b0; cls = 0; err = 0;
    while (!done) begin
      if (m_leaf[a] != 0) begin
        cls = m_cls[a]; done = 1'b1;
      end else if (m_fidx[a] >= NUM_FEAT || d == MAX_DEPTH) begin
        err = 1; done = 1'b1;
      end else begin
        a = (feat_v[m_fidx[a]] <= m_thr[a]) ? m_l[a] : m_r[a];
        d++;
      end
    end
    node = a; depth = d;
  endfunction

  function automatic logic [NODE_W-1:0] pack_node(input bit leaf, input int fidx, input bit [31:0] thr,
                                                  input int l, input int r, input int cls);
    return {leaf, 3'(fidx), thr, 8'(l), 8'(r), 4'(cls)};
  endfunction

  // Called right after a falling edge while idle; returns after the next falling edge.
  task automatic write_node(input int a, input bit leaf, input int fidx, input bit [31:0] thr,
                            input int l, input int r, input int cls);
    check("cfg_ready_idle", 64'(bus_if.cfg_ready), 64'd1);
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_addr  = 8'(a);
    bus_if.cfg_wdata = pack_node(leaf, fidx, thr, l, r, cls);
    @(negedge clk);
    bus_if.cfg_we = 1'b0;
    m_leaf[a] = int'(leaf); m_fidx[a] = fidx; m_thr[a] = thr;
    m_l[a] = l; m_r[a] = r; m_cls[a] = cls;
  endtask

  // One classification: optional same-cycle leaf write to node 0, optional result backpressure.
  task automatic run_vec(input string tag, input int hold, input bit co_wr, input int co_cls);
    logic [NUM_FEAT*FEAT_W-1:0] fv;
    int cyc;
    int e_cls, e_node, e_depth, e_err;
    for (int i = 0; i < NUM_FEAT; i++) fv[i*FEAT_W +: FEAT_W] = feat_v[i];
    if (co_wr) begin
      bus_if.cfg_we    = 1'b1;
      bus_if.cfg_addr  = 8'd0;
      bus_if.cfg_wdata = pack_node(1'b1, 0, 32'd0, 0, 0, co_cls);
      m_leaf[0] = 1; m_cls[0] = co_cls;
    end
    model(e_cls, e_node, e_depth, e_err);
    check({tag, "/in_ready_pre"}, 64'(bus_if.in_ready), 64'd1);
    bus_if.out_ready = (hold == 0);
    bus_if.in_valid  = 1'b1;
    bus_if.in_feat   = fv;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.cfg_we   = 1'b0;
    cyc = 1;
    while (bus_if.out_valid !== 1'b1 && cyc < 700) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 64'(cyc), 64'(2 * e_depth + 3));
    check({tag, "/class"}, 64'(bus_if.out_class), 64'(e_cls));
    check({tag, "/attack"}, 64'(bus_if.out_attack), 64'(e_cls != 0));
    check({tag, "/node"}, 64'(bus_if.out_node), 64'(e_node));
    check({tag, "/depth"}, 64'(bus_if.out_depth), 64'(e_depth));
    check({tag, "/error"}, 64'(bus_if.out_error), 64'(e_err));
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        bus_if.cfg_we    = 1'b1;
        bus_if.cfg_addr  = 8'd1;
        bus_if.cfg_wdata = pack_node(1'b1, 0, 32'd0, 0, 0, 5);
      end
      @(negedge clk);
      bus_if.cfg_we = 1'b0;
      check({tag, "/hold_valid"}, 64'(bus_if.out_valid), 64'd1);
      check({tag, "/hold_class"}, 64'(bus_if.out_class), 64'(e_cls));
      check({tag, "/hold_node"}, 64'(bus_if.out_node), 64'(e_node));
      check({tag, "/hold_depth"}, 64'(bus_if.out_depth), 64'(e_depth));
      check({tag, "/hold_in_ready"}, 64'(bus_if.in_ready), 64'd0);
      check({tag, "/hold_cfg_ready"}, 64'(bus_if.cfg_ready), 64'd0);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "/in_ready_post"}, 64'(bus_if.in_ready), 64'd1);
    check({tag, "/out_valid_post"}, 64'(bus_if.out_valid), 64'd0);
  endtask

  task automatic set_feats(input bit [31:0] f0);
    for (int i = 0; i < NUM_FEAT; i++) feat_v[i] = $urandom;
    feat_v[0] = f0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_if.cfg_we = 1'b0; bus_if.cfg_addr = '0; bus_if.cfg_wdata = '0;
    bus_if.in_valid = 1'b0; bus_if.in_feat = '0; bus_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst/in_ready", 64'(bus_if.in_ready), 64'd1);
    check("rst/cfg_ready", 64'(bus_if.cfg_ready), 64'd1);
    check("rst/busy", 64'(bus_if.busy), 64'd0);
    check("rst/out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst/out_class", 64'(bus_if.out_class), 64'd0);
    check("rst/out_attack", 64'(bus_if.out_attack), 64'd0);
    check("rst/out_node", 64'(bus_if.out_node), 64'd0);
    check("rst/out_depth", 64'(bus_if.out_depth), 64'd0);
    check("rst/out_error", 64'(bus_if.out_error), 64'd0);

    // Basic two-leaf tree, including the equality-goes-left boundary.
    write_node(0, 1'b0, 0, 32'd300, 1, 2, 0);
    write_node(1, 1'b1, 0, 32'd0, 0, 0, 1);
    write_node(2, 1'b1, 0, 32'd0, 0, 0, 0);
    set_feats(32'd250); run_vec("f250", 0, 1'b0, 0);
    set_feats(32'd300); run_vec("f300", 0, 1'b0, 0);
    set_feats(32'd301); run_vec("f301", 0, 1'b0, 0);

    // Root leaf.
    write_node(0, 1'b1, 0, 32'd0, 0, 0, 3);
    set_feats($urandom); run_vec("root_leaf", 0, 1'b0, 0);

    // Self-loop runs into the depth limit.
    write_node(0, 1'b0, 1, $urandom, 0, 0, 0);
    set_feats($urandom); run_vec("self_loop", 0, 1'b0, 0);

    // Feature index out of range.
    write_node(0, 1'b0, 7, 32'd300, 1, 2, 0);
    set_feats(32'd250); run_vec("bad_fidx", 0, 1'b0, 0);

    // Backpressure with a dropped write to node 1, then confirm node 1 is unchanged.
    write_node(0, 1'b0, 0, 32'd300, 1, 2, 0);
    set_feats(32'd250); run_vec("bp", 10, 1'b0, 0);
    set_feats(32'd250); run_vec("bp_rerun", 0, 1'b0, 0);

    // Reset during the fetch of the second level.
    set_feats(32'd250);
    for (int i = 0; i < NUM_FEAT; i++) bus_if.in_feat[i*FEAT_W +: FEAT_W] = feat_v[i];
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst/busy_before", 64'(bus_if.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst/out_valid", 64'(bus_if.out_valid), 64'd0);
    check("mid_rst/busy", 64'(bus_if.busy), 64'd0);
    check("mid_rst/in_ready", 64'(bus_if.in_ready), 64'd1);
    check("mid_rst/out_depth", 64'(bus_if.out_depth), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_feats(32'd250); run_vec("after_rst", 0, 1'b0, 0);

    // Write and handshake in the same idle cycle: the new root leaf must be used.
    set_feats($urandom); run_vec("co_write", 0, 1'b1, 9);

    // Randomized complete tree of depth 3 with small values so equality occurs often.
    for (int a = 0; a < 7; a++)
      write_node(a, 1'b0, int'($urandom_range(0, NUM_FEAT - 1)), $urandom_range(0, 15),
                 2 * a + 1, 2 * a + 2, 0);
    for (int a = 7; a < 15; a++)
      write_node(a, 1'b1, 0, 32'd0, 0, 0, int'($urandom_range(0, 15)));
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < NUM_FEAT; i++) feat_v[i] = $urandom_range(0, 15);
      run_vec("rand", 0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
